// File: rtl/ifetch_arbiter_if.sv
// Bus bundle between the instruction-fetch arbiter, its cores and the shared
// synchronous-read instruction memory port.
// The master modport is the arbiter's view. The slave modport is the view of
// the cores and memory that drive it.
interface ifetch_arbiter_if #(
    parameter int NCORE = 4,
    parameter int AW    = 32
);
    logic [NCORE-1:0]    req;
    logic [NCORE*AW-1:0] addr;
    logic [NCORE-1:0]    flush;
    logic [NCORE-1:0]    gnt;
    logic                mem_en;
    logic [AW-1:0]       mem_addr;
    logic [31:0]         mem_rdata;
    logic [31:0]         inst_out;
    logic [NCORE-1:0]    fetch_en;

    modport master (
        input  req, addr, flush, mem_rdata,
        output gnt, mem_en, mem_addr, inst_out, fetch_en
    );

    modport slave (
        output req, addr, flush, mem_rdata,
        input  gnt, mem_en, mem_addr, inst_out, fetch_en
    );
endinterface

// File: rtl/ifetch_arbiter.sv
// Round-robin arbiter sharing one synchronous-read instruction memory among
// NCORE cores.
// - Grant is combinational, in the same cycle as the request.
// - Return valid (fetch_en) is registered one cycle after the grant and is
//   masked by that core's flush.
// - Optional per-core stall counters are enabled by defining IFETCH_ARB_PERF_EN.
//   They add the stall_cnt port.
module ifetch_arbiter #(
    parameter int NCORE = 4,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                reset,
    ifetch_arbiter_if.master    bus
`ifdef IFETCH_ARB_PERF_EN
    ,
    output logic [NCORE*16-1:0] stall_cnt
`endif
);
    localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;

    logic [PW-1:0]    ptr;
    logic [NCORE-1:0] ereq;
    logic [NCORE-1:0] gnt_w;
    logic [NCORE-1:0] rv;
    logic [PW-1:0]    gidx;
    logic             any_gnt;
    logic [AW-1:0]    maddr;
    logic [PW:0]      ptr_nxt;

    // (base + off) mod NCORE, one bit wider than PW so the sum cannot overflow
    function automatic logic [PW:0] wrap_add(input logic [PW-1:0] base, input int off);
        logic [PW:0] s;
        s = {1'b0, base} + (PW+1)'(off);
        if (s >= (PW+1)'(NCORE)) begin
            s = s - (PW+1)'(NCORE);
        end
        return s;
    endfunction

    // Priority search starting at ptr; grants are forced off while reset is high
    always_comb begin
        ereq    = bus.req & ~bus.flush;
        gnt_w   = '0;
        gidx    = '0;
        any_gnt = 1'b0;
        if (!reset) begin
            for (int i = 0; i < NCORE; i++) begin
                for (int j = 0; j < NCORE; j++) begin
                    if (!any_gnt && (wrap_add(ptr, i) == (PW+1)'(j)) && ereq[j]) begin
                        any_gnt  = 1'b1;
                        gnt_w[j] = 1'b1;
                        gidx     = PW'(j);
                    end
                end
            end
        end
    end

    // Address mux driven by the one-hot grant; zero when idle
    always_comb begin
        maddr = '0;
        for (int j = 0; j < NCORE; j++) begin
            if (gnt_w[j]) begin
                maddr = maddr | bus.addr[j*AW +: AW];
            end
        end
    end

    assign ptr_nxt = wrap_add(gidx, 1);

    // Pointer moves past the winner only when a grant was issued.
    // The return register records who owns next cycle's memory data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            rv  <= '0;
        end else begin
            rv <= gnt_w;
            if (any_gnt) begin
                ptr <= ptr_nxt[PW-1:0];
            end
        end
    end

    assign bus.gnt      = gnt_w;
    assign bus.mem_en   = any_gnt;
    assign bus.mem_addr = maddr;
    assign bus.inst_out = bus.mem_rdata;
    // A redirect in the return cycle drops the word; memory data is simply ignored
    assign bus.fetch_en = rv & ~bus.flush;

`ifdef IFETCH_ARB_PERF_EN
    for (genvar g = 0; g < NCORE; g++) begin : gen_perf
        logic [15:0] cnt;

        // Saturating count of cycles core g wanted the port but lost arbitration
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if (ereq[g] && !gnt_w[g] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign stall_cnt[g*16 +: 16] = cnt;
    end
`endif
endmodule

// File: tb/tb_ifetch_arbiter.sv
// Directed-vector bench for ifetch_arbiter.
// - Each vector queues its hand-computed expected gnt and fetch_en.
// - A negedge monitor pops each entry and compares it with the DUT outputs.
module tb_ifetch_arbiter;
    localparam int NCORE = 4;
    localparam int AW    = 32;

    logic clk;
    logic reset;

    ifetch_arbiter_if #(.NCORE(NCORE), .AW(AW)) bus ();

`ifdef IFETCH_ARB_PERF_EN
    logic [NCORE*16-1:0] stall_cnt;
`endif

    ifetch_arbiter #(.NCORE(NCORE), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef IFETCH_ARB_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        int          id;
        logic [3:0]  gnt;
        logic [3:0]  fe;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          vec_id = 0;
    logic [31:0] core_addr [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h want %h", name, id, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] fl,
                        input logic [31:0] rd, input logic [3:0] eg, input logic [3:0] efe);
        @(posedge clk);
        #1;
        reset         = r;
        bus.req       = rq;
        bus.flush     = fl;
        bus.mem_rdata = rd;
        vec_id++;
        sb.push_back(exp_t'{vec_id, eg, efe, rd});
    endtask

    // Monitor: one expectation per cycle, compared away from the rising edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] ea;
            e  = sb.pop_front();
            ea = '0;
            for (int j = 0; j < NCORE; j++) begin
                if (e.gnt[j]) ea = core_addr[j];
            end
            chk("gnt", e.id, 32'(bus.gnt), 32'(e.gnt));
            chk("mem_en", e.id, 32'(bus.mem_en), 32'(|e.gnt));
            chk("mem_addr", e.id, bus.mem_addr, ea);
            chk("fetch_en", e.id, 32'(bus.fetch_en), 32'(e.fe));
            if (|e.fe) chk("inst_out", e.id, bus.inst_out, e.rdata);
        end
    end

    initial begin
        int guard;
        core_addr[0] = 32'h0000_0040;
        core_addr[1] = 32'h0000_0100;
        core_addr[2] = 32'h0000_0200;
        core_addr[3] = 32'h0000_0300;
        bus.addr      = {core_addr[3], core_addr[2], core_addr[1], core_addr[0]};
        reset         = 1'b1;
        bus.req       = '0;
        bus.flush     = '0;
        bus.mem_rdata = '0;

        // Held in reset with everyone requesting: nothing may be granted
        step(1, 4'b1111, 4'b0000, 32'h0,         4'b0000, 4'b0000);
        // Single requester, data returns next cycle
        step(0, 4'b0010, 4'b0000, 32'h0,         4'b0010, 4'b0000);
        step(0, 4'b0000, 4'b0000, 32'hDEADBEEF,  4'b0000, 4'b0010);
        // Back to reset, then all four request for 8 cycles
        step(1, 4'b0000, 4'b0000, 32'h0,         4'b0000, 4'b0000);
        step(0, 4'b1111, 4'b0000, 32'hA000_0000, 4'b0001, 4'b0000);
        step(0, 4'b1111, 4'b0000, 32'hA000_0001, 4'b0010, 4'b0001);
        step(0, 4'b1111, 4'b0000, 32'hA000_0002, 4'b0100, 4'b0010);
        step(0, 4'b1111, 4'b0000, 32'hA000_0003, 4'b1000, 4'b0100);
        step(0, 4'b1111, 4'b0000, 32'hA000_0004, 4'b0001, 4'b1000);
        step(0, 4'b1111, 4'b0000, 32'hA000_0005, 4'b0010, 4'b0001);
        step(0, 4'b1111, 4'b0000, 32'hA000_0006, 4'b0100, 4'b0010);
        step(0, 4'b1111, 4'b0000, 32'hA000_0007, 4'b1000, 4'b0100);
        step(0, 4'b0000, 4'b0000, 32'hA000_0008, 4'b0000, 4'b1000);
`ifdef IFETCH_ARB_PERF_EN
        #2;
        for (int c = 0; c < NCORE; c++) chk("stall_cnt", vec_id, 32'(stall_cnt[c*16 +: 16]), 32'd6);
`endif
        // Bring ptr to 1, then req=1001 alternates 3,0,3
        step(0, 4'b0001, 4'b0000, 32'hB000_0000, 4'b0001, 4'b0000);
        step(0, 4'b1001, 4'b0000, 32'hB000_0001, 4'b1000, 4'b0001);
        step(0, 4'b1001, 4'b0000, 32'hB000_0002, 4'b0001, 4'b1000);
        step(0, 4'b1001, 4'b0000, 32'hB000_0003, 4'b1000, 4'b0001);
        step(0, 4'b0000, 4'b0000, 32'hB000_0004, 4'b0000, 4'b1000);
        // Core 2 granted, flushed in its return cycle
        step(0, 4'b0100, 4'b0000, 32'hC000_0000, 4'b0100, 4'b0000);
        step(0, 4'b0000, 4'b0100, 32'hC000_0001, 4'b0000, 4'b0000);
        // ptr -> 1; flushed request on core 2 must not move ptr
        step(0, 4'b0001, 4'b0000, 32'hC000_0002, 4'b0001, 4'b0000);
        step(0, 4'b0100, 4'b0100, 32'hC000_0003, 4'b0000, 4'b0001);
        step(0, 4'b1111, 4'b0000, 32'hC000_0004, 4'b0010, 4'b0000);
        step(0, 4'b1111, 4'b0100, 32'hC000_0005, 4'b1000, 4'b0010);
        step(0, 4'b0000, 4'b0000, 32'hC000_0006, 4'b0000, 4'b1000);
        // Reset the cycle after a grant: return dropped, ptr back to 0
        step(0, 4'b0010, 4'b0000, 32'hD000_0000, 4'b0010, 4'b0000);
        step(1, 4'b0000, 4'b0000, 32'hD000_0001, 4'b0000, 4'b0000);
        step(0, 4'b1111, 4'b0000, 32'hD000_0002, 4'b0001, 4'b0000);
        step(0, 4'b0000, 4'b0000, 32'hD000_0003, 4'b0000, 4'b0001);
`ifdef IFETCH_ARB_PERF_EN
        // Saturation: preload core 3 near the top and make it lose 3 times
        step(1, 4'b0000, 4'b0000, 32'h0,         4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b0000, 32'h0,         4'b0000, 4'b0000);
        force dut.gen_perf[3].cnt = 16'hFFFE;
        #1;
        release dut.gen_perf[3].cnt;
        step(0, 4'b1111, 4'b0000, 32'hE000_0000, 4'b0001, 4'b0000);
        step(0, 4'b1111, 4'b0000, 32'hE000_0001, 4'b0010, 4'b0001);
        step(0, 4'b1111, 4'b0000, 32'hE000_0002, 4'b0100, 4'b0010);
        step(0, 4'b0000, 4'b0000, 32'hE000_0003, 4'b0000, 4'b0100);
        #2;
        chk("stall_sat", vec_id, 32'(stall_cnt[3*16 +: 16]), 32'h0000_FFFF);
        chk("stall_c2", vec_id, 32'(stall_cnt[2*16 +: 16]), 32'd2);
`endif
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_arbiter.md
# ifetch_arbiter

Round-robin arbiter that shares one synchronous-read instruction memory port among NCORE cores. Each core presents a fetch request and address. The arbiter grants one core per cycle and returns the instruction word one cycle later with a per-core valid. That valid directly drives the `en` of the core's fetch/decode pipeline register. A per-core flush kills in-flight fetches on branch redirect.

## Interface
- `NCORE`, default 4: number of requesting cores (2..8).
- `AW`, default 32: instruction address width.
- `clk`  in  1: clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  NCORE: per-core fetch request; held until granted.
- `addr`  in  NCORE*AW: flattened per-core fetch addresses; core i at `[i*AW +: AW]`.
- `flush`  in  NCORE: per-core redirect; masks that core's request and kills its in-flight return.
- `gnt`  out  NCORE: one-hot (or zero) combinational grant, same cycle as request.
- `mem_en`  out  1: memory read enable (= |gnt).
- `mem_addr`  out  AW: address of granted core, zero when idle.
- `mem_rdata`  in  32: memory data, valid the cycle after `mem_en`.
- `inst_out`  out  32: `mem_rdata` passed through, broadcast to all cores.
- `fetch_en`  out  NCORE: one-hot registered return valid; drives core i's fetch/decode register `en`.

## Operation
- Effective request: `ereq = req & ~flush`.
- Round-robin pointer `ptr` (log2 NCORE bits) names the highest-priority core.
  - Search order is ptr, ptr+1, … modulo NCORE.
  - The first set `ereq` bit wins.
- On a grant to core k, `ptr` becomes (k+1) mod NCORE. If nothing is granted, `ptr` holds.
- `mem_addr` = `addr[k]`; `mem_en` = 1 when any grant is issued.
- Return register `rv` (NCORE bits) loads `gnt` every cycle.
- `fetch_en = rv & ~flush`: a flush in the return cycle suppresses that core's valid. The memory data is still consumed and discarded.
- A core may request and be granted back-to-back when it is the only requester. Throughput is 1 fetch/cycle total.
- `inst_out` is meaningful only when some `fetch_en` bit is high; otherwise it is don't-care.

## Timing
- Grant latency: 0 cycles (combinational from `req`, `flush`, `ptr`).
- Data latency: 1 cycle. `fetch_en[k]` is high in cycle N+1 for a grant in cycle N.
- Reset (async assert, sync deassert by the system):
  - `ptr` = 0, `rv` = 0.
  - Outputs during reset: `fetch_en` = 0, `gnt` = 0, `mem_en` = 0, `mem_addr` = 0.
- Reset mid-operation: an in-flight return is dropped and no `fetch_en` pulses after reset.
- All requests simultaneous: grants rotate strictly. Each core is served once every NCORE cycles (no starvation).
- Flush and request on the same core in the same cycle: no grant to that core, and the pointer is not advanced on its behalf.
- Flush in the grant cycle and again in the return cycle: no grant is issued, so there is no return.
- Max wait for a continuously requesting core: NCORE−1 cycles.

## Configuration
- `IFETCH_ARB_PERF_EN` defined:
  - Adds output port `stall_cnt`, NCORE*16 bits.
  - Per core, a 16-bit counter increments each cycle with `ereq[i]` high and `gnt[i]` low.
  - Counters saturate at 16'hFFFF, clear only on `reset`, and reset to 0.
- `IFETCH_ARB_PERF_EN` not defined: no counters, no `stall_cnt` port. Arbitration behaviour is identical.

## Test plan
- Single requester: reset, then `req`=4'b0010, `addr[1]`=32'h100, `mem_rdata`=32'hDEADBEEF the next cycle.
  - Required: `gnt`=4'b0010, `mem_addr`=32'h100 same cycle.
  - Next cycle: `fetch_en`=4'b0010, `inst_out`=32'hDEADBEEF.
- All four request for 8 cycles from reset: grant sequence 0,1,2,3,0,1,2,3 and `fetch_en` follows one cycle later.
- `req`=4'b1001 with `ptr`=1: grant core 3, then core 0, then core 3 (alternating).
- Flush kill:
  - Core 2 granted in cycle N with `flush[2]`=1 in N+1: `fetch_en[2]`=0 in N+1.
  - `req[2]`=1 with `flush[2]`=1: `gnt[2]`=0 and `ptr` unchanged.
- Reset mid-flight: assert `reset` in the cycle after a grant.
  - `fetch_en`=0 immediately.
  - After release with `req`=4'b1111, the first grant is core 0.
- With `IFETCH_ARB_PERF_EN`: all four request continuously for 8 cycles → each `stall_cnt` = 6. Forcing a counter to 16'hFFFE and stalling 3 more cycles → it holds at 16'hFFFF.
